tag_compare: RTL and testbench

- Consumer end of the request FIFO fed by the index extractor.
- Pops one queued AXI request (read or write) and pairs it with the in-order tag-memory response for the same set.
- Compares the stored tag against the request address and emits a registered hit/miss result, with victim state, to the cache controller over a valid/ready handshake.
- Sits between the request FIFO, the tag-memory read-data channel and the cache controller.

---
 rtl/tag_compare.sv | 144 ++++++++++++++
 tb/tb_tag_compare.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_compare.sv
// tag_compare
// Consumer end of the request FIFO. Pops one queued AXI request, waits for the
// in-order tag-memory response for the same set, and presents a hit/miss
// result with victim state to the cache controller over valid/ready.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   fifo_empty_i        - request FIFO empty
//   fifo_rden_o         - FIFO pop strobe (data valid the following cycle)
//   fifo_data_i         - {rw (1=write), id, addr}
//   tag_rid_i           - tag response ID
//   tag_rdata_i         - {valid, dirty, tag}
//   tag_rvalid_i        - tag response valid
//   tag_rready_o        - tag response accept (high only while waiting for it)
//   res_valid_o         - result valid, held until res_ready_i
//   res_ready_i         - result accept
//   res_hit_o           - stored line valid and stored tag == request tag
//   res_write_o         - request was a write
//   res_id_o            - request ID
//   res_addr_o          - request address
//   res_index_o         - set index of the request
//   res_victim_dirty_o  - stored line valid, dirty and not a hit
//   res_victim_tag_o    - stored tag
//   err_id_mismatch_o   - sticky: response ID differed from request ID
module tag_compare #(
  parameter int ID_WIDTH     = 16,
  parameter int ADDR_WIDTH   = 64,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 6,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty_i,
  output logic                         fifo_rden_o,
  input  logic [ID_WIDTH+ADDR_WIDTH:0] fifo_data_i,
  input  logic [ID_WIDTH-1:0]          tag_rid_i,
  input  logic [TAG_WIDTH+1:0]         tag_rdata_i,
  input  logic                         tag_rvalid_i,
  output logic                         tag_rready_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic                         res_hit_o,
  output logic                         res_write_o,
  output logic [ID_WIDTH-1:0]          res_id_o,
  output logic [ADDR_WIDTH-1:0]        res_addr_o,
  output logic [INDEX_WIDTH-1:0]       res_index_o,
  output logic                         res_victim_dirty_o,
  output logic [TAG_WIDTH-1:0]         res_victim_tag_o,
  output logic                         err_id_mismatch_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    WAIT_TAG = 2'd2,
    RESULT   = 2'd3
  } state_t;

  state_t                  state;
  logic                    req_write;
  logic [ID_WIDTH-1:0]     req_id;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    line_valid;
  logic                    line_dirty;
  logic [TAG_WIDTH-1:0]    line_tag;
  logic                    err_sticky;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic                    hit;

  // Compare is done purely on captured request and captured tag response.
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign hit     = line_valid && (line_tag == req_tag);

  // The pop must land in the IDLE cycle itself to meet the 4-cycle pop-to-pop
  // rate, so it is a decode of the state register gated by the empty flag;
  // rst masks it so nothing is popped in a reset cycle.
  assign fifo_rden_o  = (state == IDLE) && !fifo_empty_i && !rst;
  assign tag_rready_o = (state == WAIT_TAG);
  assign res_valid_o  = (state == RESULT);

  // Result fields are driven straight from registers so they stay stable
  // for as long as the controller holds off res_ready_i.
  assign res_hit_o          = hit;
  assign res_write_o        = req_write;
  assign res_id_o           = req_id;
  assign res_addr_o         = req_addr;
  assign res_index_o        = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign res_victim_dirty_o = line_valid && line_dirty && !hit;
  assign res_victim_tag_o   = line_tag;
  assign err_id_mismatch_o  = err_sticky;

  // Request/response sequencing FSM with capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_write  <= 1'b0;
      req_id     <= '0;
      req_addr   <= '0;
      line_valid <= 1'b0;
      line_dirty <= 1'b0;
      line_tag   <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty_i) begin
            state <= CAPTURE;
          end else begin
            state <= IDLE;
          end
        end
        CAPTURE: begin
          // FIFO data is valid the cycle after the pop strobe.
          {req_write, req_id, req_addr} <= fifo_data_i;
          state                         <= WAIT_TAG;
        end
        WAIT_TAG: begin
          if (tag_rvalid_i) begin
            {line_valid, line_dirty, line_tag} <= tag_rdata_i;
            // A mismatched ID is flagged but the result is still produced.
            if (tag_rid_i != req_id) begin
              err_sticky <= 1'b1;
            end else begin
              err_sticky <= err_sticky;
            end
            state <= RESULT;
          end else begin
            state <= WAIT_TAG;
          end
        end
        RESULT: begin
          if (res_ready_i) begin
            state <= IDLE;
          end else begin
            state <= RESULT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_compare.sv
// Self-checking bench for tag_compare: directed test-plan scenarios plus a
// randomized run against a behavioural model of the hit/miss rules.
module tb_tag_compare;

  logic         clk;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [80:0]  fifo_data;
  logic [15:0]  tag_rid;
  logic [55:0]  tag_rdata;
  logic         tag_rvalid;
  logic         tag_rready;
  logic         res_valid;
  logic         res_ready;
  logic         res_hit;
  logic         res_write;
  logic [15:0]  res_id;
  logic [63:0]  res_addr;
  logic [3:0]   res_index;
  logic         res_victim_dirty;
  logic [53:0]  res_victim_tag;
  logic         err_id_mismatch;

  int checks;
  int failures;
  int cyc;
  logic [80:0] fq[$];

  tag_compare dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_empty_i       (fifo_empty),
    .fifo_rden_o        (fifo_rden),
    .fifo_data_i        (fifo_data),
    .tag_rid_i          (tag_rid),
    .tag_rdata_i        (tag_rdata),
    .tag_rvalid_i       (tag_rvalid),
    .tag_rready_o       (tag_rready),
    .res_valid_o        (res_valid),
    .res_ready_i        (res_ready),
    .res_hit_o          (res_hit),
    .res_write_o        (res_write),
    .res_id_o           (res_id),
    .res_addr_o         (res_addr),
    .res_index_o        (res_index),
    .res_victim_dirty_o (res_victim_dirty),
    .res_victim_tag_o   (res_victim_tag),
    .err_id_mismatch_o  (err_id_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {hit, write, id, addr, index, victim_dirty, victim_tag}
  function automatic logic [140:0] pack_out();
    return {res_hit, res_write, res_id, res_addr, res_index, res_victim_dirty, res_victim_tag};
  endfunction

  // Reference: request tag is the address above the 10 index+offset bits.
  function automatic logic [140:0] exp_out(input logic [80:0] req, input logic [55:0] rsp);
    logic [63:0] addr;
    logic [63:0] rtag;
    logic [63:0] stag;
    logic [63:0] idx;
    logic        v;
    logic        d;
    logic        h;
    logic        vd;
    addr = req[63:0];
    v    = rsp[55];
    d    = rsp[54];
    stag = {10'd0, rsp[53:0]};
    rtag = addr / 64'd1024;
    idx  = (addr / 64'd64) % 64'd16;
    h    = v && (rtag == stag);
    vd   = v && d && !h;
    return {h, req[80], req[79:64], addr, idx[3:0], vd, rsp[53:0]};
  endfunction

  // One clock: pop is decided by the strobe seen now; FIFO data appears next cycle.
  task automatic tick();
    bit pop;
    pop = fifo_rden;
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
    if (pop && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [80:0] e);
    fq.push_back(e);
    fifo_empty = 1'b0;
  endtask

  // Runs one request through: offers the tag response, waits for the result,
  // holds res_ready low for 'hold' cycles, then accepts it.
  task automatic run_txn(input logic [80:0] req, input bit do_push, input logic [55:0] rsp,
                         input logic [15:0] rid, input int hold, output int lat,
                         output logic [140:0] obs, output bit stable, output bit timeout);
    int t0;
    bit acc;
    if (do_push) push(req);
    tag_rdata  = rsp;
    tag_rid    = rid;
    tag_rvalid = 1'b1;
    t0 = -1; acc = 1'b0; lat = -1; obs = '0; stable = 1'b1; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (t0 < 0 && fifo_rden) t0 = cyc;
      if (tag_rready && tag_rvalid) acc = 1'b1;
      if (res_valid) begin
        timeout = 1'b0;
        lat     = cyc - t0;
        obs     = pack_out();
        break;
      end
      tick();
      if (acc) tag_rvalid = 1'b0;
    end
    tag_rvalid = 1'b0;
    if (!timeout) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        #1;
        if (!res_valid || pack_out() !== obs || fifo_rden || tag_rready) stable = 1'b0;
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_empty = 1'b1; fifo_data = '0; res_ready = 1'b0;
    tag_rvalid = 1'b1; tag_rid = 16'h1234; tag_rdata = 56'hFF_FFFF_FFFF_FFFF;
    tick(); tick(); tick();
    #1;
    checks++; if (fifo_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", fifo_rden); end
    checks++; if (tag_rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", tag_rready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (err_id_mismatch !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_id_mismatch); end
    checks++; if (pack_out() !== 141'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", pack_out()); end
    rst = 1'b0; tag_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_read_hit();
    logic [80:0] req; logic [55:0] rsp; logic [140:0] obs; int lat; bit st; bit to;
    req = {1'b0, 16'h0003, 64'h1240};
    rsp = {1'b1, 1'b0, 54'h4};
    run_txn(req, 1'b1, rsp, 16'h0003, 0, lat, obs, st, to);
    checks++; if (to) begin failures++; $display("FAIL read_hit_timeout no result"); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL read_hit_latency got=%0d exp=3", lat); end
    checks++; if (obs !== exp_out(req, rsp)) begin failures++; $display("FAIL read_hit_fields got=%h exp=%h", obs, exp_out(req, rsp)); end
    checks++; if (obs[140] !== 1'b1) begin failures++; $display("FAIL read_hit_hit got=%b exp=1", obs[140]); end
    checks++; if (obs[58:55] !== 4'h9) begin failures++; $display("FAIL read_hit_index got=%h exp=9", obs[58:55]); end
  endtask

  task automatic test_write_dirty_miss();
    logic [80:0] req; logic [55:0] rsp; logic [140:0] obs; int lat; bit st; bit to;
    req = {1'b1, 16'h0001, 64'h2640};
    rsp = {1'b1, 1'b1, 54'h7};
    run_txn(req, 1'b1, rsp, 16'h0001, 0, lat, obs, st, to);
    checks++; if (to) begin failures++; $display("FAIL wr_miss_timeout no result"); end
    checks++; if (obs !== exp_out(req, rsp)) begin failures++; $display("FAIL wr_miss_fields got=%h exp=%h", obs, exp_out(req, rsp)); end
    checks++; if (obs[54] !== 1'b1) begin failures++; $display("FAIL wr_miss_victim_dirty got=%b exp=1", obs[54]); end
  endtask

  task automatic test_invalid_line();
    logic [80:0] req; logic [55:0] rsp; logic [140:0] obs; int lat; bit st; bit to;
    req = {1'b0, 16'h0002, 64'h1240};
    rsp = {1'b0, 1'b1, 54'h4};
    run_txn(req, 1'b1, rsp, 16'h0002, 0, lat, obs, st, to);
    checks++; if (to) begin failures++; $display("FAIL invalid_timeout no result"); end
    checks++; if (obs !== exp_out(req, rsp)) begin failures++; $display("FAIL invalid_fields got=%h exp=%h", obs, exp_out(req, rsp)); end
    checks++; if (obs[140] !== 1'b0 || obs[54] !== 1'b0) begin failures++; $display("FAIL invalid_hit_vd got=%b%b exp=00", obs[140], obs[54]); end
  endtask

  task automatic test_backpressure();
    logic [80:0] ra; logic [80:0] rb; logic [55:0] rsp; logic [140:0] obs; int lat; bit st; bit to;
    ra  = {1'b0, 16'h00A1, 64'h0000_0000_0001_2340};
    rb  = {1'b1, 16'h00B2, 64'h0000_0000_0003_4580};
    rsp = {1'b1, 1'b1, 54'h48};
    push(ra);
    push(rb);
    run_txn(ra, 1'b0, rsp, 16'h00A1, 5, lat, obs, st, to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout no result"); end
    checks++; if (!st) begin failures++; $display("FAIL bp_stable outputs moved during hold exp=stable"); end
    checks++; if (obs !== exp_out(ra, rsp)) begin failures++; $display("FAIL bp_fields_a got=%h exp=%h", obs, exp_out(ra, rsp)); end
    checks++; if (fifo_rden !== 1'b1) begin failures++; $display("FAIL bp_second_pop got=%b exp=1", fifo_rden); end
    run_txn(rb, 1'b0, rsp, 16'h00B2, 0, lat, obs, st, to);
    checks++; if (to || obs !== exp_out(rb, rsp)) begin failures++; $display("FAIL bp_fields_b got=%h exp=%h", obs, exp_out(rb, rsp)); end
  endtask

  task automatic test_random();
    logic [80:0] req; logic [55:0] rsp; logic [140:0] obs; logic [63:0] a; logic [63:0] rt;
    int lat; bit st; bit to; int hold;
    for (int n = 0; n < 24; n++) begin
      a   = {$urandom, $urandom};
      req = {1'($urandom_range(0, 1)), 16'($urandom), a};
      rt  = a / 64'd1024;
      rsp[55] = 1'($urandom_range(0, 1));
      rsp[54] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) rsp[53:0] = rt[53:0];
      else rsp[53:0] = {22'($urandom), $urandom};
      hold = $urandom_range(0, 2);
      run_txn(req, 1'b1, rsp, req[79:64], hold, lat, obs, st, to);
      checks++; if (to || obs !== exp_out(req, rsp)) begin failures++; $display("FAIL rand_fields n=%0d got=%h exp=%h", n, obs, exp_out(req, rsp)); end
      checks++; if (lat !== 3 || !st) begin failures++; $display("FAIL rand_timing n=%0d lat=%0d stable=%0d exp lat=3 stable=1", n, lat, st); end
    end
    checks++; if (err_id_mismatch !== 1'b0) begin failures++; $display("FAIL rand_no_err got=%b exp=0", err_id_mismatch); end
  endtask

  task automatic test_early_mismatch();
    logic [80:0] req; logic [55:0] rsp; logic [140:0] obs; int lat; bit st; bit to; bit bad;
    req = {1'b0, 16'h0004, 64'h1240};
    rsp = {1'b1, 1'b0, 54'h4};
    tag_rvalid = 1'b1; tag_rid = 16'h0005; tag_rdata = rsp;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (tag_rready || fifo_rden) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin failures++; $display("FAIL early_not_accepted rready/rden high while idle exp=0"); end
    run_txn(req, 1'b1, rsp, 16'h0005, 0, lat, obs, st, to);
    checks++; if (to || lat !== 3) begin failures++; $display("FAIL early_latency got=%0d exp=3", lat); end
    checks++; if (obs !== exp_out(req, rsp)) begin failures++; $display("FAIL early_fields got=%h exp=%h", obs, exp_out(req, rsp)); end
    checks++; if (err_id_mismatch !== 1'b1) begin failures++; $display("FAIL mismatch_err got=%b exp=1", err_id_mismatch); end
    tick(); tick(); tick(); #1;
    checks++; if (err_id_mismatch !== 1'b1) begin failures++; $display("FAIL mismatch_sticky got=%b exp=1", err_id_mismatch); end
  endtask

  task automatic test_reset_mid();
    logic [80:0] ra; logic [80:0] rb; logic [55:0] rsp; logic [140:0] obs; int lat; bit st; bit to; bit seen;
    ra  = {1'b1, 16'h0010, 64'h0000_0000_0000_5540};
    rb  = {1'b0, 16'h0011, 64'h0000_0000_0000_1240};
    rsp = {1'b1, 1'b1, 54'h4};
    tag_rvalid = 1'b0;
    push(ra);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (tag_rready) begin seen = 1'b1; break; end
      tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL rstmid_wait_tag never reached exp=rready"); end
    rst = 1'b1;
    push(rb);
    tick(); #1;
    checks++; if (fifo_rden !== 1'b0 || tag_rready !== 1'b0 || res_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b%b%b exp=000", fifo_rden, tag_rready, res_valid); end
    checks++; if (err_id_mismatch !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", err_id_mismatch); end
    checks++; if (pack_out() !== 141'd0) begin failures++; $display("FAIL rstmid_fields got=%h exp=0", pack_out()); end
    rst = 1'b0;
    #1;
    checks++; if (fifo_rden !== 1'b1) begin failures++; $display("FAIL rstmid_fresh_pop got=%b exp=1", fifo_rden); end
    run_txn(rb, 1'b0, rsp, 16'h0011, 0, lat, obs, st, to);
    checks++; if (to || lat !== 3 || obs !== exp_out(rb, rsp)) begin
      failures++; $display("FAIL rstmid_after got=%h lat=%0d exp=%h lat=3", obs, lat, exp_out(rb, rsp)); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    test_reset();
    test_read_hit();
    test_write_dirty_miss();
    test_invalid_line();
    test_backpressure();
    test_random();
    test_early_mismatch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
